// File: rtl/branch_resolver_if.sv
// branch_resolver_if: EX-stage operands in, PC-select redirect and statistics out
interface branch_resolver_if #(
    parameter int CNT_W = 16
) ();
    logic             valid_in;
    logic             stall;
    logic [2:0]       br_op;
    logic [31:0]      pc_in;
    logic [31:0]      imm;
    logic [25:0]      jtarget;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic             pc_src;
    logic [31:0]      branchtarget;
    logic             flush;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    modport slave (
        input  valid_in, stall, br_op, pc_in, imm, jtarget, rs_val, rt_val,
        output pc_src, branchtarget, flush, branch_count, taken_count
    );

    modport master (
        output valid_in, stall, br_op, pc_in, imm, jtarget, rs_val, rt_val,
        input  pc_src, branchtarget, flush, branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: resolves EX branches/jumps into a registered one-cycle redirect plus flush
module branch_resolver #(
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    branch_resolver_if.slave bus
);
    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t           r_state;
    logic             r_pc_src;
    logic             r_flush;
    logic [31:0]      r_target;
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_taken_count;

    logic        w_is_br;
    logic        w_eq;
    logic        w_lt;
    logic        w_taken;
    logic        w_sample;
    logic [31:0] w_pc4;
    logic [31:0] w_target;

    assign w_is_br  = (bus.br_op != 3'b000) && (bus.br_op != 3'b111);
    assign w_eq     = bus.rs_val == bus.rt_val;
    assign w_lt     = $signed(bus.rs_val) < $signed(bus.rt_val);
    assign w_taken  = (bus.br_op == 3'b001) ? w_eq :
                      (bus.br_op == 3'b010) ? !w_eq :
                      (bus.br_op == 3'b011) ? w_lt :
                      (bus.br_op == 3'b100) ? !w_lt :
                      (bus.br_op == 3'b101) || (bus.br_op == 3'b110);
    assign w_pc4    = bus.pc_in + 32'd4;
    assign w_target = (bus.br_op == 3'b101) ? {w_pc4[31:28], bus.jtarget, 2'b00} :
                      (bus.br_op == 3'b110) ? bus.rs_val :
                      w_pc4 + (bus.imm << 2);
    assign w_sample = bus.valid_in && !bus.stall && (r_state == IDLE) && w_is_br;

    // Resolution FSM: sample in IDLE, hold the redirect in REDIRECT until an unstalled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pc_src       <= 1'b0;
            r_flush        <= 1'b0;
            r_target       <= '0;
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else if (r_state == REDIRECT) begin
            if (!bus.stall) begin
                r_state  <= IDLE;
                r_pc_src <= 1'b0;
                r_flush  <= 1'b0;
            end
        end else if (w_sample) begin
            if (r_branch_count != '1) r_branch_count <= r_branch_count + 1'b1;
            if (w_taken) begin
                r_state  <= REDIRECT;
                r_pc_src <= 1'b1;
                r_flush  <= 1'b1;
                r_target <= w_target;
                if (r_taken_count != '1) r_taken_count <= r_taken_count + 1'b1;
            end
        end
    end

    assign bus.pc_src       = r_pc_src;
    assign bus.flush        = r_flush;
    assign bus.branchtarget = r_target;
    assign bus.branch_count = r_branch_count;
    assign bus.taken_count  = r_taken_count;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed checks of branch resolution, squash, stall, reset and saturation
module tb_branch_resolver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    branch_resolver_if #(.CNT_W(16)) b ();
    branch_resolver_if #(.CNT_W(4))  s ();

    branch_resolver #(.CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(b));
    branch_resolver #(.CNT_W(4))  u_sat (.clk(clk), .rst(rst), .bus(s));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic ps, input logic [31:0] tgt,
                            input logic [15:0] bc, input logic [15:0] tc);
        chk({tag, ".pc_src"}, {31'd0, b.pc_src}, {31'd0, ps});
        chk({tag, ".flush"}, {31'd0, b.flush}, {31'd0, ps});
        chk({tag, ".target"}, b.branchtarget, tgt);
        chk({tag, ".bcnt"}, {16'd0, b.branch_count}, {16'd0, bc});
        chk({tag, ".tcnt"}, {16'd0, b.taken_count}, {16'd0, tc});
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc,
                         input logic [31:0] im, input logic [25:0] jt,
                         input logic [31:0] rs, input logic [31:0] rt);
        b.valid_in = v;
        b.br_op    = op;
        b.pc_in    = pc;
        b.imm      = im;
        b.jtarget  = jt;
        b.rs_val   = rs;
        b.rt_val   = rt;
    endtask

    initial begin
        b.stall = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 26'd0, 32'd0, 32'd0);
        s.valid_in = 1'b0; s.stall = 1'b0; s.br_op = 3'd5; s.pc_in = 32'd0;
        s.imm = 32'd0; s.jtarget = 26'd1; s.rs_val = 32'd0; s.rt_val = 32'd0;
        #12;
        chk_main("reset", 1'b0, 32'd0, 16'd0, 16'd0);
        rst = 1'b0;
        step();
        // beq taken, negative offset
        drive(1'b1, 3'd1, 32'h0000_0100, 32'hFFFF_FFFE, 26'd0, 32'd5, 32'd5);
        step();
        chk_main("beq", 1'b1, 32'h0000_00FC, 16'd1, 16'd1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 26'd0, 32'd0, 32'd0);
        step();
        chk_main("beq_end", 1'b0, 32'h0000_00FC, 16'd1, 16'd1);
        // blt signed taken
        drive(1'b1, 3'd3, 32'h0000_0200, 32'd4, 26'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        chk_main("blt", 1'b1, 32'h0000_0214, 16'd2, 16'd2);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 26'd0, 32'd0, 32'd0);
        step();
        chk_main("blt_end", 1'b0, 32'h0000_0214, 16'd2, 16'd2);
        // bge signed not taken, then back-to-back not-taken bne
        drive(1'b1, 3'd4, 32'h0000_0300, 32'd8, 26'd0, 32'hFFFF_FFFF, 32'd1);
        step();
        chk_main("bge_nt", 1'b0, 32'h0000_0214, 16'd3, 16'd2);
        drive(1'b1, 3'd2, 32'h0000_0304, 32'd8, 26'd0, 32'd7, 32'd7);
        step();
        chk_main("bne_nt", 1'b0, 32'h0000_0214, 16'd4, 16'd2);
        // op 111 behaves as none
        drive(1'b1, 3'd7, 32'h0000_0308, 32'd8, 26'd0, 32'd7, 32'd7);
        step();
        chk_main("op7", 1'b0, 32'h0000_0214, 16'd4, 16'd2);
        // j then squashed jr
        drive(1'b1, 3'd5, 32'hF000_0000, 32'd0, 26'h3FF_FFFF, 32'd0, 32'd0);
        step();
        chk_main("j", 1'b1, 32'hFFFF_FFFC, 16'd5, 16'd3);
        drive(1'b1, 3'd6, 32'hF000_0004, 32'd0, 26'd0, 32'h0000_1234, 32'd0);
        step();
        chk_main("jr_squash", 1'b0, 32'hFFFF_FFFC, 16'd5, 16'd3);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 26'd0, 32'd0, 32'd0);
        step();
        // misaligned jr, then stall during REDIRECT
        drive(1'b1, 3'd6, 32'h0000_0400, 32'd0, 26'd0, 32'h0000_4001, 32'd0);
        step();
        chk_main("jr", 1'b1, 32'h0000_4001, 16'd6, 16'd4);
        b.stall = 1'b1;
        drive(1'b1, 3'd2, 32'h0000_0404, 32'd16, 26'd0, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_main("redir_stall", 1'b1, 32'h0000_4001, 16'd6, 16'd4);
        end
        b.stall = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 26'd0, 32'd0, 32'd0);
        step();
        chk_main("stall_end", 1'b0, 32'h0000_4001, 16'd6, 16'd4);
        // stall in IDLE: nothing sampled
        b.stall = 1'b1;
        drive(1'b1, 3'd2, 32'h0000_0500, 32'd0, 26'd0, 32'd3, 32'd3);
        step();
        chk_main("idle_stall", 1'b0, 32'h0000_4001, 16'd6, 16'd4);
        b.stall = 1'b0;
        // reset asserted mid-cycle while in REDIRECT
        drive(1'b1, 3'd5, 32'h1000_0000, 32'd0, 26'd8, 32'd0, 32'd0);
        step();
        chk_main("j2", 1'b1, 32'h1000_0020, 16'd7, 16'd5);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 26'd0, 32'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk_main("async_rst", 1'b0, 32'd0, 16'd0, 16'd0);
        #2 rst = 1'b0;
        step();
        chk_main("post_rst", 1'b0, 32'd0, 16'd0, 16'd0);
        drive(1'b1, 3'd1, 32'h0000_0000, 32'd1, 26'd0, 32'd9, 32'd9);
        step();
        chk_main("post_rst_beq", 1'b1, 32'h0000_0008, 16'd1, 16'd1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 26'd0, 32'd0, 32'd0);
        // saturation: 20 taken jumps two cycles apart on the 4-bit instance
        s.valid_in = 1'b1;
        for (int i = 0; i < 28; i++) step();
        chk("sat14.bcnt", {28'd0, s.branch_count}, 32'd14);
        chk("sat14.tcnt", {28'd0, s.taken_count}, 32'd14);
        for (int i = 0; i < 12; i++) step();
        chk("sat.bcnt", {28'd0, s.branch_count}, 32'd15);
        chk("sat.tcnt", {28'd0, s.taken_count}, 32'd15);
        chk("sat.target", s.branchtarget, 32'd4);
        s.valid_in = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
